// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: sync, data-enable, pixel coordinates, line/frame strobes, look-ahead fetch.
// Latency: outputs reflect hc/vc of the previous CE cycle; no backpressure, CE=0 freezes all state.
module vga_timing_gen #(
   parameter int P_WIDTH = 11,
   parameter int H_ACT   = 640,
   parameter int H_FRONT = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BACK  = 48,
   parameter int V_ACT   = 480,
   parameter int V_FRONT = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BACK  = 33,
   parameter bit HS_POL  = 1'b0,
   parameter bit VS_POL  = 1'b0,
   parameter int LEAD    = 2
) (
   input  logic               VGA_CLK,
   input  logic               RST_N,
   input  logic               CE,
   output logic               VGA_HS,
   output logic               VGA_VS,
   output logic               DE,
   output logic [P_WIDTH-1:0] X,
   output logic [P_WIDTH-1:0] Y,
   output logic               LINE_START,
   output logic               FRAME_START,
   output logic               FETCH_EN,
   output logic [P_WIDTH-1:0] FETCH_X,
   output logic [P_WIDTH-1:0] FETCH_Y
);

   localparam int H_TOT = H_SYNC + H_BACK + H_ACT + H_FRONT;
   localparam int V_TOT = V_SYNC + V_BACK + V_ACT + V_FRONT;

   localparam logic [P_WIDTH-1:0] H_LAST   = P_WIDTH'(H_TOT - 1);
   localparam logic [P_WIDTH-1:0] V_LAST   = P_WIDTH'(V_TOT - 1);
   localparam logic [P_WIDTH-1:0] H_SYNC_C = P_WIDTH'(H_SYNC);
   localparam logic [P_WIDTH-1:0] V_SYNC_C = P_WIDTH'(V_SYNC);
   localparam logic [P_WIDTH-1:0] H_AST    = P_WIDTH'(H_SYNC + H_BACK);
   localparam logic [P_WIDTH-1:0] H_AEND   = P_WIDTH'(H_SYNC + H_BACK + H_ACT);
   localparam logic [P_WIDTH-1:0] V_AST    = P_WIDTH'(V_SYNC + V_BACK);
   localparam logic [P_WIDTH-1:0] V_AEND   = P_WIDTH'(V_SYNC + V_BACK + V_ACT);

   // Fetch column is one bit wider so hc+LEAD past the line end cannot alias into the active range.
   localparam logic [P_WIDTH:0]   F_AST    = (P_WIDTH+1)'(H_SYNC + H_BACK);
   localparam logic [P_WIDTH:0]   F_AEND   = (P_WIDTH+1)'(H_SYNC + H_BACK + H_ACT);
   localparam logic [P_WIDTH:0]   LEAD_C   = (P_WIDTH+1)'(LEAD);

   logic [P_WIDTH-1:0] hc;
   logic [P_WIDTH-1:0] vc;
   logic [P_WIDTH:0]   fetch_hc;
   logic               h_act;
   logic               v_act;
   logic               f_act;
   logic               hc_wrap;
   logic               vc_wrap;

   always_comb begin
      fetch_hc = {1'b0, hc} + LEAD_C;
      h_act    = (hc >= H_AST) && (hc < H_AEND);
      v_act    = (vc >= V_AST) && (vc < V_AEND);
      f_act    = (fetch_hc >= F_AST) && (fetch_hc < F_AEND);
      hc_wrap  = (hc == H_LAST);
      vc_wrap  = (vc == V_LAST);
   end

   always_ff @(posedge VGA_CLK) begin
      if (!RST_N) begin
         hc          <= '0;
         vc          <= '0;
         VGA_HS      <= ~HS_POL;
         VGA_VS      <= ~VS_POL;
         DE          <= 1'b0;
         X           <= '0;
         Y           <= '0;
         LINE_START  <= 1'b0;
         FRAME_START <= 1'b0;
         FETCH_EN    <= 1'b0;
         FETCH_X     <= '0;
         FETCH_Y     <= '0;
      end else if (CE) begin
         hc <= hc_wrap ? '0 : hc + 1'b1;
         if (hc_wrap) begin
            vc <= vc_wrap ? '0 : vc + 1'b1;
         end

         VGA_HS      <= (hc < H_SYNC_C) ? HS_POL : ~HS_POL;
         VGA_VS      <= (vc < V_SYNC_C) ? VS_POL : ~VS_POL;
         DE          <= h_act && v_act;
         X           <= (h_act && v_act) ? hc - H_AST : '0;
         Y           <= (h_act && v_act) ? vc - V_AST : '0;
         LINE_START  <= (hc == '0);
         FRAME_START <= (hc == '0) && (vc == '0);
         FETCH_EN    <= f_act && v_act;
         FETCH_X     <= (f_act && v_act) ? P_WIDTH'(fetch_hc - F_AST) : '0;
         FETCH_Y     <= (f_act && v_act) ? vc - V_AST : '0;
      end else begin
         // Strobes mark enabled cycles only; everything else holds.
         LINE_START  <= 1'b0;
         FRAME_START <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 15x8 raster: default polarity/LEAD=2, inverted polarity, LEAD=0.
module tb_vga_timing_gen;

   localparam int W = 11;
   localparam int N = 500;

   logic clk = 1'b0;
   logic rst_n;
   logic ce;

   always #5 clk = ~clk;

   logic         hs0, vs0, de0, ls0, fs0, fe0;
   logic [W-1:0] x0, y0, fx0, fy0;
   logic         hs1, vs1, de1, ls1, fs1, fe1;
   logic [W-1:0] x1, y1, fx1, fy1;
   logic         hs2, vs2, de2, ls2, fs2, fe2;
   logic [W-1:0] x2, y2, fx2, fy2;

   vga_timing_gen #(.P_WIDTH(W), .H_ACT(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                    .V_ACT(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                    .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(2)) dut0 (
      .VGA_CLK(clk), .RST_N(rst_n), .CE(ce), .VGA_HS(hs0), .VGA_VS(vs0), .DE(de0),
      .X(x0), .Y(y0), .LINE_START(ls0), .FRAME_START(fs0), .FETCH_EN(fe0),
      .FETCH_X(fx0), .FETCH_Y(fy0));

   vga_timing_gen #(.P_WIDTH(W), .H_ACT(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                    .V_ACT(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                    .HS_POL(1'b1), .VS_POL(1'b1), .LEAD(2)) dut1 (
      .VGA_CLK(clk), .RST_N(rst_n), .CE(ce), .VGA_HS(hs1), .VGA_VS(vs1), .DE(de1),
      .X(x1), .Y(y1), .LINE_START(ls1), .FRAME_START(fs1), .FETCH_EN(fe1),
      .FETCH_X(fx1), .FETCH_Y(fy1));

   vga_timing_gen #(.P_WIDTH(W), .H_ACT(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                    .V_ACT(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                    .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(0)) dut2 (
      .VGA_CLK(clk), .RST_N(rst_n), .CE(ce), .VGA_HS(hs2), .VGA_VS(vs2), .DE(de2),
      .X(x2), .Y(y2), .LINE_START(ls2), .FRAME_START(fs2), .FETCH_EN(fe2),
      .FETCH_X(fx2), .FETCH_Y(fy2));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Sample traces; index i is the sample after the i-th clock edge of a run.
   logic         t_hs[N], t_vs[N], t_de[N], t_ls[N], t_fs[N], t_fe[N];
   logic [W-1:0] t_x[N], t_y[N], t_fx[N], t_fy[N];
   logic         t_hs1[N], t_vs1[N];
   logic         t_fe2[N];
   logic [W-1:0] t_fx2[N], t_fy2[N];

   task automatic record(input int i);
      t_hs[i] = hs0; t_vs[i] = vs0; t_de[i] = de0; t_ls[i] = ls0; t_fs[i] = fs0;
      t_fe[i] = fe0; t_x[i] = x0; t_y[i] = y0; t_fx[i] = fx0; t_fy[i] = fy0;
      t_hs1[i] = hs1; t_vs1[i] = vs1;
      t_fe2[i] = fe2; t_fx2[i] = fx2; t_fy2[i] = fy2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ce    = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   int cnt, mis, rises, first_pos, second_pos;

   initial begin
      // Reset state
      do_reset();
      check_val("rst_de", de0, 0);
      check_val("rst_x", x0, 0);
      check_val("rst_y", y0, 0);
      check_val("rst_hs", hs0, 1);
      check_val("rst_vs", vs0, 1);
      check_val("rst_hs_pol1", hs1, 0);
      check_val("rst_vs_pol1", vs1, 0);
      check_val("rst_fs", fs0, 0);
      check_val("rst_ls", ls0, 0);
      check_val("rst_fe", fe0, 0);
      check_val("rst_fx", fx0, 0);

      // Free-running, CE=1
      rst_n = 1'b1;
      for (int i = 0; i < 250; i++) begin
         @(negedge clk);
         record(i);
      end

      cnt = 0; first_pos = -1; second_pos = -1;
      for (int i = 0; i < 250; i++) if (t_fs[i]) begin
         cnt++;
         if (first_pos < 0) first_pos = i; else if (second_pos < 0) second_pos = i;
      end
      check_val("fs_count", cnt, 3);
      check_val("fs_first", first_pos, 0);
      check_val("fs_period", second_pos, 120);

      cnt = 0; second_pos = -1;
      for (int i = 0; i < 250; i++) if (t_ls[i]) begin
         cnt++;
         if (i > 0 && second_pos < 0) second_pos = i;
      end
      check_val("ls_count", cnt, 17);
      check_val("ls_period", second_pos, 15);

      // Active region: first active sample is line 3, column 5 -> index 50
      cnt = 0; rises = 0;
      for (int i = 0; i < 120; i++) begin
         if (t_de[i]) cnt++;
         if (i > 0 && t_de[i] && !t_de[i-1]) rises++;
      end
      check_val("de_per_frame", cnt, 32);
      check_val("active_lines", rises, 4);
      check_val("de_before", t_de[49], 0);
      for (int k = 0; k < 8; k++) begin
         check_val("de_run", t_de[50+k], 1);
         check_val("x_run", t_x[50+k], k);
      end
      check_val("de_after", t_de[58], 0);
      check_val("x_blank", t_x[58], 0);
      check_val("de_line2", t_de[65], 1);
      check_val("y_row0", t_y[50], 0);
      check_val("y_row1", t_y[65], 1);
      check_val("y_row3", t_y[95], 3);
      check_val("de_row_last", t_de[110], 0);

      // Sync widths and polarity
      cnt = 0;
      for (int i = 0; i < 15; i++) if (!t_hs[i]) cnt++;
      check_val("hs_low_cnt", cnt, 3);
      check_val("hs_low_pos", t_hs[2], 0);
      check_val("hs_idle_pos", t_hs[3], 1);
      cnt = 0;
      for (int i = 0; i < 120; i++) if (!t_vs[i]) cnt++;
      check_val("vs_low_cnt", cnt, 30);
      check_val("vs_edge", t_vs[30], 1);
      cnt = 0;
      for (int i = 0; i < 15; i++) if (t_hs1[i]) cnt++;
      check_val("hs_pol1_cnt", cnt, 3);
      check_val("hs_pol1_pos", t_hs1[0], 1);
      cnt = 0;
      for (int i = 0; i < 120; i++) if (t_vs1[i]) cnt++;
      check_val("vs_pol1_cnt", cnt, 30);

      // Look-ahead: LEAD=2 leads by two samples, LEAD=0 matches DE/X/Y
      mis = 0;
      for (int i = 0; i < 240; i++)
         if (t_fe[i] !== t_de[i+2] || t_fx[i] !== t_x[i+2] || t_fy[i] !== t_y[i+2]) mis++;
      check_val("fetch_lead2", mis, 0);
      check_val("fetch_first", t_fe[48], 1);
      check_val("fetch_x7", t_fx[55], 7);
      mis = 0;
      for (int i = 0; i < 240; i++)
         if (t_fe2[i] !== t_de[i] || t_fx2[i] !== t_x[i] || t_fy2[i] !== t_y[i]) mis++;
      check_val("fetch_lead0", mis, 0);

      // CE alternating 1,0: periods double, strobes only on enabled cycles
      do_reset();
      rst_n = 1'b1;
      for (int j = 0; j < 480; j++) begin
         ce = (j % 2 == 0);
         @(negedge clk);
         record(j);
      end
      ce = 1'b1;
      cnt = 0; second_pos = -1;
      for (int j = 0; j < 480; j++) if (t_fs[j]) begin
         cnt++;
         if (j > 0 && second_pos < 0) second_pos = j;
      end
      check_val("ce_fs_count", cnt, 2);
      check_val("ce_fs_period", second_pos, 240);
      second_pos = -1;
      for (int j = 1; j < 480; j++) if (t_ls[j] && second_pos < 0) second_pos = j;
      check_val("ce_ls_period", second_pos, 30);
      cnt = 0; mis = 0;
      for (int j = 1; j < 480; j += 2) begin
         if (t_ls[j] || t_fs[j]) cnt++;
         if (t_hs[j] !== t_hs[j-1] || t_vs[j] !== t_vs[j-1] || t_de[j] !== t_de[j-1] ||
             t_x[j] !== t_x[j-1] || t_y[j] !== t_y[j-1] || t_fe[j] !== t_fe[j-1] ||
             t_fx[j] !== t_fx[j-1] || t_fy[j] !== t_fy[j-1]) mis++;
      end
      check_val("ce_strobe_off", cnt, 0);
      check_val("ce_hold", mis, 0);
      cnt = 0;
      for (int j = 0; j < 240; j++) if (!t_vs[j]) cnt++;
      check_val("ce_vs_low_cnt", cnt, 60);

      // Reset pulse mid-active-line at X=4
      do_reset();
      rst_n = 1'b1;
      for (int i = 0; i < 55; i++) @(negedge clk);
      check_val("mid_de", de0, 1);
      check_val("mid_x", x0, 4);
      rst_n = 1'b0;
      @(negedge clk);
      check_val("abort_de", de0, 0);
      check_val("abort_x", x0, 0);
      check_val("abort_hs", hs0, 1);
      check_val("abort_vs", vs0, 1);
      check_val("abort_fs", fs0, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("restart_fs", fs0, 1);
      check_val("restart_ls", ls0, 1);
      check_val("restart_hs", hs0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
